// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: shared phase encoding and default 640x480@60 timing constants
package vga_timing_pkg;
  typedef enum logic [1:0] {PH_SYNC, PH_BP, PH_ACTIVE, PH_FP} phase_t;
  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;
  function automatic phase_t next_phase(phase_t p);
    return phase_t'(p + 2'd1);
  endfunction
endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: position counter, wrap strobe and SYNC/BP/ACTIVE/FP phase machine for one axis
module vga_axis_counter import vga_timing_pkg::*; #(
  parameter int SYNC   = 96,
  parameter int BP     = 48,
  parameter int ACTIVE = 640,
  parameter int FP     = 16,
  parameter int CW     = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          adv,
  output logic [CW-1:0] count,
  output logic [CW-1:0] count_nxt,
  output phase_t        phase_nxt,
  output logic          wrap
);
  localparam int TOTAL = SYNC + BP + ACTIVE + FP;
  localparam logic [CW-1:0] END_SYNC = CW'(SYNC - 1);
  localparam logic [CW-1:0] END_BP   = CW'(SYNC + BP - 1);
  localparam logic [CW-1:0] END_ACT  = CW'(SYNC + BP + ACTIVE - 1);
  localparam logic [CW-1:0] LAST     = CW'(TOTAL - 1);
  if (SYNC < 1 || BP < 1 || ACTIVE < 1 || FP < 1) begin : g_bad_len
    $error("vga_axis_counter: every phase length must be at least 1");
  end
  if (64'(TOTAL) > (64'd1 << CW)) begin : g_bad_total
    $error("vga_axis_counter: axis total does not fit in CW bits");
  end
  logic [CW-1:0] count_q, count_d, phase_end;
  phase_t phase_q, phase_d;
  // next count and phase: each phase hands over to the next on its last count
  always_comb begin
    phase_end = phase_q == PH_SYNC ? END_SYNC : phase_q == PH_BP ? END_BP : phase_q == PH_ACTIVE ? END_ACT : LAST;
    wrap = adv && count_q == LAST;
    count_d = !adv ? count_q : wrap ? '0 : count_q + CW'(1);
    phase_d = adv && count_q == phase_end ? next_phase(phase_q) : phase_q;
  end
  // count and phase state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      phase_q <= PH_SYNC;
    end else begin
      count_q <= count_d;
      phase_q <= phase_d;
    end
  end
  assign count     = count_q;
  assign count_nxt = count_d;
  assign phase_nxt = phase_d;
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA sync/blanking/coordinate generator with all outputs registered and aligned to the counts
module vga_timing_gen import vga_timing_pkg::*; #(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CW       = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          pix_en,
  output logic          hSync,
  output logic          vSync,
  output logic          bright,
  output logic [CW-1:0] hCount,
  output logic [CW-1:0] vCount,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          line_start,
  output logic          frame_start,
  output logic          vblank
);
  localparam logic [CW-1:0] H_OFF = CW'(H_SYNC + H_BP);
  localparam logic [CW-1:0] V_OFF = CW'(V_SYNC + V_BP);
  logic [CW-1:0] h_cnt_d, v_cnt_d, x_d, y_d, x_q, y_q;
  phase_t h_ph_d, v_ph_d;
  logic h_wrap, v_wrap;
  logic hsync_d, vsync_d, bright_d, vblank_d, line_start_d, frame_start_d;
  logic hsync_q, vsync_q, bright_q, vblank_q, line_start_q, frame_start_q;
  vga_axis_counter #(.SYNC(H_SYNC), .BP(H_BP), .ACTIVE(H_ACTIVE), .FP(H_FP), .CW(CW)) u_h (
    .clk(clk), .rst(reset), .adv(pix_en), .count(hCount),
    .count_nxt(h_cnt_d), .phase_nxt(h_ph_d), .wrap(h_wrap)
  );
  vga_axis_counter #(.SYNC(V_SYNC), .BP(V_BP), .ACTIVE(V_ACTIVE), .FP(V_FP), .CW(CW)) u_v (
    .clk(clk), .rst(reset), .adv(h_wrap), .count(vCount),
    .count_nxt(v_cnt_d), .phase_nxt(v_ph_d), .wrap(v_wrap)
  );
  // outputs derived from the next counts/phases so they land alongside the counters
  always_comb begin
    bright_d      = h_ph_d == PH_ACTIVE && v_ph_d == PH_ACTIVE;
    hsync_d       = h_ph_d == PH_SYNC ? HS_POL : !HS_POL;
    vsync_d       = v_ph_d == PH_SYNC ? VS_POL : !VS_POL;
    vblank_d      = v_ph_d != PH_ACTIVE;
    x_d           = bright_d ? h_cnt_d - H_OFF : '0;
    y_d           = bright_d ? v_cnt_d - V_OFF : '0;
    line_start_d  = h_wrap;
    frame_start_d = h_wrap && v_wrap;
  end
  // output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      hsync_q       <= HS_POL;
      vsync_q       <= VS_POL;
      bright_q      <= 1'b0;
      vblank_q      <= 1'b1;
      x_q           <= '0;
      y_q           <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      bright_q      <= bright_d;
      vblank_q      <= vblank_d;
      x_q           <= x_d;
      y_q           <= y_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end
  assign hSync       = hsync_q;
  assign vSync       = vsync_q;
  assign bright      = bright_q;
  assign vblank      = vblank_q;
  assign x           = x_q;
  assign y           = y_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: tick-count reference model checks two configurations every cycle, plus literal timing points
module tb_vga_timing_gen;
  typedef struct {int hs, hb, ha, hf, vs, vb, va, vf, hp, vp;} cfg_t;
  typedef struct {int hc, vc, hs, vs, br, x, y, vb, ls, fs;} out_t;
  logic clk = 1'b0;
  logic rst_a = 1'b1, rst_b = 1'b1, en_a = 1'b0, en_b = 1'b0;
  logic a_hs, a_vs, a_br, a_ls, a_fs, a_vb;
  logic [15:0] a_hc, a_vc, a_x, a_y;
  logic b_hs, b_vs, b_br, b_ls, b_fs, b_vb;
  logic [7:0] b_hc, b_vc, b_x, b_y;
  int n_chk = 0, n_pass = 0;
  int t[2];
  bit ls[2], fs[2], valid[2];
  out_t ce, ca;
  always #5 clk = ~clk;
  vga_timing_gen u_a (
    .clk(clk), .reset(rst_a), .pix_en(en_a), .hSync(a_hs), .vSync(a_vs), .bright(a_br),
    .hCount(a_hc), .vCount(a_vc), .x(a_x), .y(a_y), .line_start(a_ls), .frame_start(a_fs), .vblank(a_vb)
  );
  vga_timing_gen #(
    .H_ACTIVE(1), .H_FP(1), .H_SYNC(1), .H_BP(1), .V_ACTIVE(3), .V_FP(2), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .CW(8)
  ) u_b (
    .clk(clk), .reset(rst_b), .pix_en(en_b), .hSync(b_hs), .vSync(b_vs), .bright(b_br),
    .hCount(b_hc), .vCount(b_vc), .x(b_x), .y(b_y), .line_start(b_ls), .frame_start(b_fs), .vblank(b_vb)
  );
  function automatic cfg_t cfg(int i);
    cfg_t c;
    if (i == 0) c = '{96, 48, 640, 16, 2, 33, 480, 10, 0, 0};
    else c = '{1, 1, 1, 1, 2, 1, 3, 2, 1, 1};
    return c;
  endfunction
  function automatic out_t exp_out(int i);
    cfg_t c;
    out_t o;
    int ht, h, v;
    bit hact, vact;
    c = cfg(i);
    ht = c.hs + c.hb + c.ha + c.hf;
    h = t[i] % ht;
    v = t[i] / ht;
    hact = h >= c.hs + c.hb && h < c.hs + c.hb + c.ha;
    vact = v >= c.vs + c.vb && v < c.vs + c.vb + c.va;
    o.hc = h;
    o.vc = v;
    o.hs = h < c.hs ? c.hp : 1 - c.hp;
    o.vs = v < c.vs ? c.vp : 1 - c.vp;
    o.br = int'(hact && vact);
    o.x = hact && vact ? h - c.hs - c.hb : 0;
    o.y = hact && vact ? v - c.vs - c.vb : 0;
    o.vb = int'(!vact);
    o.ls = int'(ls[i]);
    o.fs = int'(fs[i]);
    return o;
  endfunction
  function automatic out_t act_out(int i);
    out_t o;
    if (i == 0) o = '{int'(a_hc), int'(a_vc), int'(a_hs), int'(a_vs), int'(a_br), int'(a_x), int'(a_y), int'(a_vb), int'(a_ls), int'(a_fs)};
    else o = '{int'(b_hc), int'(b_vc), int'(b_hs), int'(b_vs), int'(b_br), int'(b_x), int'(b_y), int'(b_vb), int'(b_ls), int'(b_fs)};
    return o;
  endfunction
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", n, act, exp);
  endtask
  // reference model: position is the number of pixel ticks since reset, modulo the frame
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      automatic cfg_t c = cfg(i);
      automatic int ht = c.hs + c.hb + c.ha + c.hf;
      automatic int tot = ht * (c.vs + c.vb + c.va + c.vf);
      automatic int nt = (t[i] + 1) % tot;
      automatic bit r = i == 0 ? rst_a : rst_b;
      automatic bit e = i == 0 ? en_a : en_b;
      if (r) begin
        t[i] <= 0; ls[i] <= 1'b0; fs[i] <= 1'b0; valid[i] <= 1'b1;
      end else if (e) begin
        t[i] <= nt; ls[i] <= nt % ht == 0; fs[i] <= nt == 0;
      end else begin
        ls[i] <= 1'b0; fs[i] <= 1'b0;
      end
    end
  end
  // compare every output of both DUTs against the model on every cycle
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (valid[i]) begin
        automatic string p = i == 0 ? "A" : "B";
        ce = exp_out(i);
        ca = act_out(i);
        chk({p, ".hCount"}, ca.hc, ce.hc);
        chk({p, ".vCount"}, ca.vc, ce.vc);
        chk({p, ".hSync"}, ca.hs, ce.hs);
        chk({p, ".vSync"}, ca.vs, ce.vs);
        chk({p, ".bright"}, ca.br, ce.br);
        chk({p, ".x"}, ca.x, ce.x);
        chk({p, ".y"}, ca.y, ce.y);
        chk({p, ".vblank"}, ca.vb, ce.vb);
        chk({p, ".line_start"}, ca.ls, ce.ls);
        chk({p, ".frame_start"}, ca.fs, ce.fs);
      end
    end
  end
  initial begin
    fork
      begin : proc_a
        int cnt, k, n;
        repeat (3) @(negedge clk);
        chk("A.rst_hCount", a_hc, 0);
        chk("A.rst_vCount", a_vc, 0);
        chk("A.rst_hSync", a_hs, 0);
        chk("A.rst_vSync", a_vs, 0);
        chk("A.rst_vblank", a_vb, 1);
        chk("A.rst_bright", a_br, 0);
        chk("A.rst_line_start", a_ls, 0);
        chk("A.rst_frame_start", a_fs, 0);
        rst_a = 1'b0;
        en_a = 1'b1;
        cnt = 0;
        for (int i = 0; i < 800; i++) begin
          if (a_hs == 1'b0) cnt++;
          @(negedge clk);
        end
        chk("A.hsync_low_clks", cnt, 96);
        chk("A.no_frame_pulse_after_release", a_fs, 0);
        k = 0;
        while (!a_br && k < 30000) begin @(negedge clk); k++; end
        chk("A.first_bright_hCount", a_hc, 144);
        chk("A.first_bright_vCount", a_vc, 35);
        k = 0;
        while (!a_ls && k < 1000) begin @(negedge clk); k++; end
        n = 0;
        do begin @(negedge clk); n++; end while (!a_ls && n < 2000);
        chk("A.line_period", n, 800);
        k = 0;
        while (!a_ls && k < 4000) begin @(negedge clk); en_a = ~en_a; k++; end
        while (a_ls && k < 4000) begin @(negedge clk); en_a = ~en_a; k++; end
        k = 0;
        while (!a_ls && k < 4000) begin @(negedge clk); en_a = ~en_a; k++; end
        @(negedge clk);
        en_a = ~en_a;
        n = 1;
        chk("A.line_start_width_half_rate", a_ls, 0);
        while (!a_ls && n < 4000) begin @(negedge clk); en_a = ~en_a; n++; end
        chk("A.line_period_half_rate", n, 1600);
        en_a = 1'b1;
        k = 0;
        while (a_hc != 16'd300 && k < 2000) begin @(negedge clk); k++; end
        chk("A.reach_hCount_300", a_hc, 300);
        rst_a = 1'b1;
        @(negedge clk);
        chk("A.midreset_hCount", a_hc, 0);
        chk("A.midreset_vCount", a_vc, 0);
        chk("A.midreset_bright", a_br, 0);
        chk("A.midreset_frame_start", a_fs, 0);
        rst_a = 1'b0;
        repeat (3000) begin
          en_a = $urandom_range(0, 3) != 0;
          @(negedge clk);
        end
      end
      begin : proc_b
        int k;
        int seq_h[5] = '{0, 1, 2, 3, 0};
        int seq_s[5] = '{1, 0, 0, 0, 1};
        repeat (2) @(negedge clk);
        chk("B.rst_hSync", b_hs, 1);
        chk("B.rst_vSync", b_vs, 1);
        rst_b = 1'b0;
        en_b = 1'b1;
        for (int i = 0; i < 5; i++) begin
          chk("B.seq_hCount", b_hc, seq_h[i]);
          chk("B.seq_hSync", b_hs, seq_s[i]);
          @(negedge clk);
        end
        k = 0;
        while (!(b_hc == 8'd2 && b_vc == 8'd3) && k < 100) begin @(negedge clk); k++; end
        chk("B.first_active_bright", b_br, 1);
        chk("B.first_active_x", b_x, 0);
        chk("B.first_active_y", b_y, 0);
        k = 0;
        while (!(b_hc == 8'd3 && b_vc == 8'd7) && k < 100) begin @(negedge clk); k++; end
        chk("B.last_pixel_reached", b_vc, 7);
        @(negedge clk);
        chk("B.wrap_hCount", b_hc, 0);
        chk("B.wrap_vCount", b_vc, 0);
        chk("B.wrap_frame_start", b_fs, 1);
        chk("B.wrap_line_start", b_ls, 1);
        chk("B.wrap_vSync", b_vs, 1);
        chk("B.wrap_vblank", b_vb, 1);
        @(negedge clk);
        chk("B.frame_start_width", b_fs, 0);
        repeat (6000) begin
          en_b = $urandom_range(0, 2) != 0;
          rst_b = $urandom_range(0, 399) == 0;
          @(negedge clk);
        end
      end
    join
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter H_ACTIVE, default 640: visible pixels per line.
REQ-002 Parameter H_FP, default 16: horizontal front porch, in pixels.
REQ-003 Parameter H_SYNC, default 96: horizontal sync width, in pixels.
REQ-004 Parameter H_BP, default 48: horizontal back porch, in pixels.
REQ-005 Parameter V_ACTIVE, default 480: visible lines per frame.
REQ-006 Parameter V_FP, default 10: vertical front porch, in lines.
REQ-007 Parameter V_SYNC, default 2: vertical sync width, in lines.
REQ-008 Parameter V_BP, default 33: vertical back porch, in lines.
REQ-009 Parameters HS_POL and VS_POL, default 0: asserted sync level (0 means active-low).
REQ-010 Parameter CW, default 16: width of the counter and coordinate outputs.
REQ-011 clk  in  1  the one clock; all logic is on its rising edge.
REQ-012 reset  in  1  synchronous, active-high reset.
REQ-013 pix_en  in  1  pixel tick; counters advance only on cycles where it is 1.
REQ-014 hSync, vSync  out  1  sync outputs, driven at the polarity set by HS_POL/VS_POL.
REQ-015 bright  out  1  high only inside the active region on both axes.
REQ-016 hCount, vCount  out  CW  raw position in the line and frame.
REQ-017 x, y  out  CW  active-area coordinates, each 0 outside the active region.
REQ-018 line_start, frame_start  out  1  single-clk pulses.
REQ-019 vblank  out  1  high whenever the vertical position is outside the active region.

Function
REQ-020 H_TOTAL = H_SYNC+H_BP+H_ACTIVE+H_FP; V_TOTAL = V_SYNC+V_BP+V_ACTIVE+V_FP.
REQ-021 Phase order on each axis is SYNC, BP, ACTIVE, FP, with SYNC starting at count 0.
REQ-022 Horizontal phase is SYNC for hCount<H_SYNC and BP for hCount<H_SYNC+H_BP.
REQ-023 Horizontal phase is ACTIVE for hCount<H_SYNC+H_BP+H_ACTIVE, else FP; the vertical axis follows the same rule with V_* values.
REQ-024 Each axis carries an explicit phase state register that changes exactly at the boundaries in REQ-021 to REQ-023.
REQ-025 Advance: on a pix_en=1 cycle, hCount increments; at hCount=H_TOTAL-1 it wraps to 0 and vCount increments.
REQ-026 At hCount=H_TOTAL-1 and vCount=V_TOTAL-1 together, both counters wrap to 0 on the same edge.
REQ-027 When pix_en=0, the counters and all level outputs hold their values.
REQ-028 All outputs are registered and mutually aligned: every output describes the hCount/vCount value presented in the same cycle.
REQ-029 hSync is asserted (=HS_POL) iff the horizontal phase is SYNC; vSync is asserted (=VS_POL) iff the vertical phase is SYNC.
REQ-030 bright = (h phase ACTIVE) AND (v phase ACTIVE).
REQ-031 x = hCount-(H_SYNC+H_BP) and y = vCount-(V_SYNC+V_BP) while bright=1; both are 0 otherwise.
REQ-032 line_start is high for exactly one clk, in the first cycle where hCount=0 after a wrap.
REQ-033 frame_start is high for exactly one clk, in the first cycle where hCount=0 and vCount=0 after a wrap; line_start is also high in that cycle.
REQ-034 The pulses in REQ-032 and REQ-033 are one clk wide regardless of how often pix_en occurs.
REQ-035 Arithmetic is unsigned CW-bit; H_TOTAL and V_TOTAL must each be at most 2^CW.
REQ-036 Every porch and sync parameter must be at least 1; an illegal value is an elaboration error.

Reset
REQ-037 While reset=1, reset takes priority over pix_en.
REQ-038 Reset values: hCount=vCount=0, both phases SYNC, hSync=HS_POL, vSync=VS_POL, vblank=1.
REQ-039 Reset values: bright=0, x=y=0, line_start=0, frame_start=0.
REQ-040 Asserting reset mid-frame returns to the REQ-038/REQ-039 state on the next edge.
REQ-041 After reset releases, the first frame_start pulse comes at the first wrap to (0,0); no pulse is generated on release itself.

Structure
REQ-042 Shared package vga_timing_pkg holds the phase enum (SYNC, BP, ACTIVE, FP) and the default 640x480 timing constants.
REQ-043 One sub-module, vga_axis_counter, holds the count, the wrap and the phase state machine for one axis.
REQ-044 vga_axis_counter is instantiated twice, once per axis; the vertical instance advances on the horizontal wrap strobe.

Verification
REQ-045 Defaults with pix_en=1 -> hSync low for 96 clks, bright first high at hCount=144, line period 800 clks, frame period 420000 clks.
REQ-046 pix_en high every 2nd clk -> line period 1600 clks; line_start and frame_start still exactly 1 clk wide.
REQ-047 HS_POL=1, VS_POL=1 -> hSync high for hCount 0..95, vSync high for vCount 0..1, all other timing unchanged.
REQ-048 reset asserted at hCount=300, vCount=200 -> next cycle hCount=vCount=0, bright=0, frame_start=0.
REQ-049 Each of H_SYNC, H_BP, H_ACTIVE, H_FP set to 1 (H_TOTAL=4) -> hCount sequence 0,1,2,3,0 with phases SYNC, BP, ACTIVE, FP; x=0 at hCount=2.
REQ-050 Defaults, last pixel (799,524) -> next tick gives (0,0), frame_start=1, line_start=1, vSync asserted, vblank=1.
